cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
Transmit end of the common data bus. Collects completed results from NUM_EU execution units through per-unit valid/ready handshakes and buffers them in small per-unit FIFOs. Each cycle it arbitrates up to CDB_WIDTH buffered results onto cdb_out/cdb_bc, which feed every issue queue, the register file and the ROB. Buffered results are squashed on branch mispredict (EBR) and on late_flush.

Parameters:
NUM_EU, 4, number of execution units feeding the bus
FIFO_DEPTH, 2, entries per per-unit result FIFO (power of 2, >=2)
CDB_WIDTH is not a parameter; it is the package constant in params.

Ports:
clk  input  1  sole clock
rst  input  1  synchronous, active-low reset (asserted when 0)
eu_valid[NUM_EU]  input  1  unit i offers a result
eu_data[NUM_EU]  input  cdb_t  result payload (prd_s, rob_id, rd value, ...)
eu_ebr_mask[NUM_EU]  input  EBR_MASK_SIZE  branch-dependency mask of the result
eu_ready[NUM_EU]  output  1  unit i's FIFO can accept
cdb_out[CDB_WIDTH]  output  cdb_t  broadcast payload per slot
cdb_bc[CDB_WIDTH]  output  1  slot k valid this cycle
late_flush  input  1  ROB full-pipeline flush
bra_done  input  1  branch resolved this cycle
bra_mispredict  input  1  resolved branch mispredicted
bra_id  input  EBR_MASK_SIZE  one-hot id of the resolved branch

Behaviour:
- Reset (rst==0 at a clk edge): all FIFOs empty, rr_ptr=0. While rst==0: eu_ready=0, cdb_bc=0, cdb_out='0.
- eu_ready[i] = FIFO i not full. It is a function of registered count only; a pop in the same cycle does not free space for a same-cycle push.
- Push on eu_valid[i] && eu_ready[i], with these exceptions:
  - Dropped if late_flush.
  - Dropped if bra_done && bra_mispredict && (eu_ebr_mask & bra_id) != 0.
  - If bra_done && !bra_mispredict, the stored mask is eu_ebr_mask & ~bra_id.
- Latency: a result accepted at edge N is broadcast no earlier than the cycle after edge N. There is no bypass.
- Squash: each FIFO entry with (mask & bra_id) != 0 under bra_done && bra_mispredict is invalidated at the edge. A head squashed this cycle is not eligible for grant this cycle. FIFO compaction happens in the FIFO, with no holes visible at the head.
- Correct prediction (bra_done && !bra_mispredict): bra_id bit is cleared from all stored masks at the edge.
- Arbitration, combinational from registered state plus bra_* and late_flush:
  - Scan units rr_ptr, rr_ptr+1, ... mod NUM_EU.
  - Grant the first CDB_WIDTH units whose head is valid and not being squashed.
  - The k-th grant drives slot k: cdb_out[k] = head payload, cdb_bc[k] = 1.
  - Unused slots: cdb_bc=0, cdb_out='0.
- Granted heads pop at the edge.
- rr_ptr update: rr_ptr_next = (last granted index + 1) mod NUM_EU; unchanged if nothing is granted.
- late_flush: cdb_bc all 0 that cycle, no pops, all FIFOs empty next cycle, rr_ptr unchanged. late_flush has priority over branch events.
- Simultaneous push and pop on a non-full FIFO: both occur, count unchanged. Pointers wrap mod FIFO_DEPTH.
- Each unit broadcasts at most once per cycle; results from one unit are broadcast in order.

Decomposition:
- Package (params / rv32i_types) holds:
  - cdb_entry_t = {cdb_t data, logic [EBR_MASK_SIZE-1:0] ebr_mask, logic valid}
  - NUM_EU default
  - existing CDB_WIDTH and EBR_MASK_SIZE
- Sub-module cdb_result_fifo (one per unit):
  - valid-per-entry circular FIFO with push/pop
  - mask resolve via the existing ebr_resolve per entry
  - compaction of squashed entries
  - exposes head, empty, full

Test Plan (NUM_EU=4, CDB_WIDTH=2, FIFO_DEPTH=2):
1. Reset held 3 cycles, then released -> eu_ready=0 and cdb_bc=0 during reset; eu_ready=4'b1111 the cycle after release.
2. Units 0,1,2 push prd_s=5,6,7 at edge N -> cycle N+1: slot0 prd_s=5, slot1 prd_s=6, rr_ptr=2. Cycle N+2: slot0 prd_s=7 only, cdb_bc=2'b01.
3. Unit 3 pushes 3 results back-to-back with no grants (other units saturating) -> eu_ready[3]=0 after 2 accepts; the third is held by the unit until ready returns to 1.
4. Unit 0 holds entries with masks 4'b0010 and 4'b0001; bra_done=1, bra_mispredict=1, bra_id=4'b0010 -> first entry never broadcast; second entry is the head and eligible in the next cycle.
5. bra_done=1, bra_mispredict=0, bra_id=4'b0001 on entry mask 4'b0011 -> stored mask becomes 4'b0010. A later mispredict on 4'b0001 does not squash it.
6. FIFOs holding 5 results; late_flush=1 with a simultaneous push on unit 2 -> cdb_bc=0 that cycle; all FIFOs empty next cycle; no broadcast of any pre-flush or pushed result.

Source files
------------

// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and constants for the common-data-bus transmit end.
// Also holds the branch-mask helpers used by every per-unit result FIFO.
package cdb_broadcaster_pkg;

    localparam int CDB_WIDTH      = 2;
    localparam int EBR_MASK_SIZE  = 4;
    localparam int NUM_EU_DEFAULT = 4;
    localparam int PRD_W          = 6;
    localparam int ROB_W          = 5;

    typedef logic [EBR_MASK_SIZE-1:0] ebr_mask_t;

    typedef struct packed {
        logic [PRD_W-1:0] prd_s;
        logic [ROB_W-1:0] rob_id;
        logic [31:0]      rd_v;
    } cdb_t;

    typedef struct packed {
        cdb_t      data;
        ebr_mask_t ebr_mask;
        logic      valid;
    } cdb_entry_t;

    // A result dies when the branch it depends on resolves as mispredicted.
    function automatic logic ebr_kill(input ebr_mask_t mask, input logic bra_done,
                                      input logic bra_mispredict, input ebr_mask_t bra_id);
        return bra_done && bra_mispredict && ((mask & bra_id) != '0);
    endfunction

    function automatic ebr_mask_t ebr_resolve(input ebr_mask_t mask, input logic bra_done,
                                              input logic bra_mispredict, input ebr_mask_t bra_id);
        return (bra_done && !bra_mispredict) ? (mask & ~bra_id) : mask;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-unit result FIFO: circular storage that drops squashed entries and
// re-packs the survivors behind the head so no holes ever reach the bus.
module cdb_result_fifo
    import cdb_broadcaster_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  cdb_t      push_data,
    input  ebr_mask_t push_mask,
    input  logic      pop,
    input  logic      late_flush,
    input  logic      bra_done,
    input  logic      bra_mispredict,
    input  ebr_mask_t bra_id,
    output cdb_t      head_data,
    output logic      head_ok,
    output logic      empty,
    output logic      full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t       mem_reg  [DEPTH];
    cdb_entry_t       mem_next [DEPTH];
    logic [PTR_W-1:0] head_reg, head_next;
    logic [CNT_W-1:0] count_reg, count_next;

    cdb_entry_t       head_entry;
    cdb_entry_t       scan_entry;
    logic             pop_eff;
    logic [CNT_W-1:0] kept;
    logic [PTR_W-1:0] rd_idx, wr_idx;

    always_comb begin
        head_entry = mem_reg[head_reg];
        empty      = (count_reg == '0);
        full       = (count_reg == CNT_W'(DEPTH));
        head_data  = head_entry.data;
        // A head being squashed this cycle must not reach the bus.
        head_ok    = !empty && head_entry.valid && !late_flush &&
                     !ebr_kill(head_entry.ebr_mask, bra_done, bra_mispredict, bra_id);
    end

    always_comb begin
        mem_next = mem_reg;
        for (int e = 0; e < DEPTH; e++) begin
            mem_next[e].valid = 1'b0;
        end
        pop_eff    = pop && head_ok;
        head_next  = head_reg + PTR_W'(pop_eff);
        kept       = '0;
        rd_idx     = '0;
        wr_idx     = '0;
        scan_entry = '0;

        // Walk entries oldest first and re-pack survivors starting at the new head.
        for (int j = 0; j < DEPTH; j++) begin
            rd_idx     = head_reg + PTR_W'(j);
            scan_entry = mem_reg[rd_idx];
            if ((CNT_W'(j) < count_reg) && !(j == 0 && pop_eff) &&
                !ebr_kill(scan_entry.ebr_mask, bra_done, bra_mispredict, bra_id)) begin
                wr_idx           = head_next + kept[PTR_W-1:0];
                mem_next[wr_idx] = '{data:     scan_entry.data,
                                     ebr_mask: ebr_resolve(scan_entry.ebr_mask, bra_done,
                                                           bra_mispredict, bra_id),
                                     valid:    1'b1};
                kept             = kept + CNT_W'(1);
            end
        end

        if (push && !ebr_kill(push_mask, bra_done, bra_mispredict, bra_id)) begin
            wr_idx           = head_next + kept[PTR_W-1:0];
            mem_next[wr_idx] = '{data:     push_data,
                                 ebr_mask: ebr_resolve(push_mask, bra_done, bra_mispredict, bra_id),
                                 valid:    1'b1};
            kept             = kept + CNT_W'(1);
        end
        count_next = kept;

        if (late_flush) begin
            head_next  = head_reg;
            count_next = '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_next[e].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg  <= '0;
            count_reg <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_reg[e] <= '0;
            end
        end else begin
            head_reg  <= head_next;
            count_reg <= count_next;
            for (int e = 0; e < DEPTH; e++) begin
                mem_reg[e] <= mem_next[e];
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common-data-bus transmit end: buffers execution-unit results and grants up
// to CDB_WIDTH of them per cycle in round-robin order starting at rr_ptr.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int NUM_EU     = NUM_EU_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_EU-1:0]    eu_valid,
    input  cdb_t                 eu_data     [NUM_EU],
    input  ebr_mask_t            eu_ebr_mask [NUM_EU],
    output logic [NUM_EU-1:0]    eu_ready,
    output cdb_t                 cdb_out     [CDB_WIDTH],
    output logic [CDB_WIDTH-1:0] cdb_bc,
    input  logic                 late_flush,
    input  logic                 bra_done,
    input  logic                 bra_mispredict,
    input  ebr_mask_t            bra_id
);

    localparam int RR_W   = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;
    localparam int GNT_W  = $clog2(CDB_WIDTH + 1);
    localparam int SLOT_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

    logic [RR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    cdb_t              head_data [NUM_EU];
    logic [NUM_EU-1:0] head_ok, fifo_empty, fifo_full, push, pop;

    logic [RR_W:0]     scan_sum;
    logic [RR_W-1:0]   unit_idx, last_idx;
    logic [GNT_W-1:0]  grant_cnt;

    // Ready depends only on registered occupancy; a same-cycle pop frees nothing.
    assign eu_ready = rst ? ~fifo_full : '0;

    generate
        for (genvar gi = 0; gi < NUM_EU; gi++) begin : g_eu
            assign push[gi] = eu_valid[gi] && eu_ready[gi];

            cdb_result_fifo #(
                .DEPTH(FIFO_DEPTH)
            ) u_fifo (
                .clk           (clk),
                .rst           (rst),
                .push          (push[gi]),
                .push_data     (eu_data[gi]),
                .push_mask     (eu_ebr_mask[gi]),
                .pop           (pop[gi]),
                .late_flush    (late_flush),
                .bra_done      (bra_done),
                .bra_mispredict(bra_mispredict),
                .bra_id        (bra_id),
                .head_data     (head_data[gi]),
                .head_ok       (head_ok[gi]),
                .empty         (fifo_empty[gi]),
                .full          (fifo_full[gi])
            );
        end
    endgenerate

    always_comb begin
        cdb_bc = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            cdb_out[k] = '0;
        end
        pop       = '0;
        grant_cnt = '0;
        last_idx  = rr_ptr_reg;
        scan_sum  = '0;
        unit_idx  = '0;

        for (int off = 0; off < NUM_EU; off++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (RR_W + 1)'(off);
            unit_idx = (scan_sum >= (RR_W + 1)'(NUM_EU)) ?
                       RR_W'(scan_sum - (RR_W + 1)'(NUM_EU)) : RR_W'(scan_sum);
            if (rst && (grant_cnt < GNT_W'(CDB_WIDTH)) &&
                !fifo_empty[unit_idx] && head_ok[unit_idx]) begin
                cdb_out[grant_cnt[SLOT_W-1:0]] = head_data[unit_idx];
                cdb_bc[grant_cnt[SLOT_W-1:0]]  = 1'b1;
                pop[unit_idx]                  = 1'b1;
                last_idx                       = unit_idx;
                grant_cnt                      = grant_cnt + GNT_W'(1);
            end
        end

        if (grant_cnt == '0) begin
            rr_ptr_next = rr_ptr_reg;
        end else if (last_idx == RR_W'(NUM_EU - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = last_idx + RR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Randomised bench for cdb_broadcaster against a queue-based reference model,
// preceded by directed scenarios with hand-computed expectations.
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    localparam int NEU   = 4;
    localparam int DEPTH = 2;
    localparam int DW    = $bits(cdb_t);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NEU-1:0]       eu_valid;
    cdb_t                 eu_data     [NEU];
    ebr_mask_t            eu_ebr_mask [NEU];
    logic [NEU-1:0]       eu_ready;
    cdb_t                 cdb_out     [CDB_WIDTH];
    logic [CDB_WIDTH-1:0] cdb_bc;
    logic                 late_flush, bra_done, bra_mispredict;
    ebr_mask_t            bra_id;

    cdb_broadcaster #(.NUM_EU(NEU), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .eu_valid      (eu_valid),
        .eu_data       (eu_data),
        .eu_ebr_mask   (eu_ebr_mask),
        .eu_ready      (eu_ready),
        .cdb_out       (cdb_out),
        .cdb_bc        (cdb_bc),
        .late_flush    (late_flush),
        .bra_done      (bra_done),
        .bra_mispredict(bra_mispredict),
        .bra_id        (bra_id)
    );

    typedef struct {
        cdb_t      d;
        ebr_mask_t m;
    } ment_t;

    ment_t                mq [NEU][$];
    int                   m_rr;
    logic [NEU-1:0]       exp_ready, exp_gnt;
    logic [CDB_WIDTH-1:0] exp_bc;
    cdb_t                 exp_out [CDB_WIDTH];
    int                   exp_n, exp_last;
    int                   errors = 0;
    int                   checks = 0;
    int                   cyc    = 0;

    function automatic bit killed(input ebr_mask_t m);
        return bra_done && bra_mispredict && ((m & bra_id) != '0);
    endfunction

    function automatic ebr_mask_t resolved(input ebr_mask_t m);
        return (bra_done && !bra_mispredict) ? (m & ~bra_id) : m;
    endfunction

    function automatic cdb_t mk(input logic [5:0] p);
        cdb_t d;
        d        = '0;
        d.prd_s  = p;
        d.rob_id = p[4:0];
        d.rd_v   = {26'h0, p} ^ 32'hA5A5_0000;
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, want);
        end
    endtask

    task automatic model_expect();
        exp_bc   = '0;
        exp_gnt  = '0;
        exp_n    = 0;
        exp_last = 0;
        for (int k = 0; k < CDB_WIDTH; k++) exp_out[k] = '0;
        for (int i = 0; i < NEU; i++) exp_ready[i] = rst && (mq[i].size() < DEPTH);
        if (rst && !late_flush) begin
            for (int off = 0; off < NEU; off++) begin
                int u;
                u = (m_rr + off) % NEU;
                if (exp_n < CDB_WIDTH && mq[u].size() > 0 && !killed(mq[u][0].m)) begin
                    exp_out[exp_n] = mq[u][0].d;
                    exp_bc[exp_n]  = 1'b1;
                    exp_gnt[u]     = 1'b1;
                    exp_n++;
                    exp_last = u;
                end
            end
        end
    endtask

    task automatic model_commit();
        ment_t nq[$];
        if (!rst || late_flush) begin
            for (int i = 0; i < NEU; i++) mq[i].delete();
            if (!rst) m_rr = 0;
        end else begin
            for (int i = 0; i < NEU; i++) begin
                nq = {};
                if (exp_gnt[i]) void'(mq[i].pop_front());
                for (int j = 0; j < mq[i].size(); j++) begin
                    if (!killed(mq[i][j].m)) nq.push_back('{mq[i][j].d, resolved(mq[i][j].m)});
                end
                if (eu_valid[i] && exp_ready[i] && !killed(eu_ebr_mask[i]))
                    nq.push_back('{eu_data[i], resolved(eu_ebr_mask[i])});
                mq[i] = nq;
            end
            if (exp_n > 0) m_rr = (exp_last + 1) % NEU;
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        rst            = 1'b1;
        eu_valid       = '0;
        late_flush     = 1'b0;
        bra_done       = 1'b0;
        bra_mispredict = 1'b0;
        bra_id         = '0;
        for (int i = 0; i < NEU; i++) begin
            eu_data[i]     = '0;
            eu_ebr_mask[i] = '0;
        end
    endtask

    // Compare every DUT output against the model once inputs have settled.
    task automatic eval();
        #1;
        model_expect();
        chk("eu_ready", 64'(eu_ready), 64'(exp_ready));
        chk("cdb_bc", 64'(cdb_bc), 64'(exp_bc));
        for (int k = 0; k < CDB_WIDTH; k++)
            chk($sformatf("cdb_out%0d", k), 64'(cdb_out[k]), 64'(exp_out[k]));
        $display("cyc=%0d rst=%b flush=%b bra=%b%b id=%b valid=%b ready=%b bc=%b s0=%0d s1=%0d",
                 cyc, rst, late_flush, bra_done, bra_mispredict, bra_id, eu_valid, eu_ready,
                 cdb_bc, cdb_out[0].prd_s, cdb_out[1].prd_s);
    endtask

    task automatic commit();
        @(posedge clk);
        model_commit();
        cyc++;
    endtask

    task automatic idle_cycle();
        begin_cycle();
        eval();
        commit();
    endtask

    task automatic reset_cycle();
        begin_cycle();
        rst = 1'b0;
        eval();
        commit();
    endtask

    task automatic push_unit(input int u, input logic [5:0] p, input ebr_mask_t m);
        eu_valid[u]    = 1'b1;
        eu_data[u]     = mk(p);
        eu_ebr_mask[u] = m;
    endtask

    initial begin
        logic [63:0] r;
        rst = 1'b0; eu_valid = '0; late_flush = 1'b0; bra_done = 1'b0;
        bra_mispredict = 1'b0; bra_id = '0;
        for (int i = 0; i < NEU; i++) begin
            eu_data[i] = '0;
            eu_ebr_mask[i] = '0;
        end
        m_rr = 0;

        // Reset held three cycles, then released.
        for (int n = 0; n < 3; n++) begin
            begin_cycle();
            rst = 1'b0;
            eval();
            chk("rst_ready", 64'(eu_ready), 64'h0);
            chk("rst_bc", 64'(cdb_bc), 64'h0);
            commit();
        end
        begin_cycle();
        eval();
        chk("ready_after_rst", 64'(eu_ready), 64'hF);
        commit();

        // Three units push together; two broadcast next cycle, the third after.
        begin_cycle();
        push_unit(0, 6'd5, '0); push_unit(1, 6'd6, '0); push_unit(2, 6'd7, '0);
        eval(); commit();
        begin_cycle(); eval();
        chk("t2_bc_first", 64'(cdb_bc), 64'h3);
        chk("t2_slot0", 64'(cdb_out[0].prd_s), 64'd5);
        chk("t2_slot1", 64'(cdb_out[1].prd_s), 64'd6);
        commit();
        begin_cycle(); eval();
        chk("t2_bc_second", 64'(cdb_bc), 64'h1);
        chk("t2_slot0_b", 64'(cdb_out[0].prd_s), 64'd7);
        commit();

        // Unit 3 fills while units 0 and 1 win both slots.
        reset_cycle();
        begin_cycle();
        push_unit(0, 6'd10, '0); push_unit(1, 6'd11, '0); push_unit(3, 6'd30, '0);
        eval(); commit();
        begin_cycle();
        push_unit(0, 6'd12, '0); push_unit(1, 6'd13, '0); push_unit(3, 6'd31, '0);
        eval();
        chk("t3_bc_others", 64'(cdb_bc), 64'h3);
        commit();
        begin_cycle();
        push_unit(3, 6'd32, '0);
        eval();
        chk("t3_ready3_full", 64'(eu_ready[3]), 64'd0);
        chk("t3_slot0_u3", 64'(cdb_out[0].prd_s), 64'd30);
        commit();
        begin_cycle();
        push_unit(3, 6'd32, '0);
        eval();
        chk("t3_ready3_back", 64'(eu_ready[3]), 64'd1);
        commit();
        for (int n = 0; n < 4; n++) idle_cycle();

        // Mispredict squashes a stored head; the entry behind it survives.
        reset_cycle();
        begin_cycle();
        push_unit(0, 6'd20, '0); push_unit(1, 6'd21, '0); push_unit(2, 6'd40, 4'b0010);
        eval(); commit();
        begin_cycle();
        push_unit(2, 6'd41, 4'b0001);
        eval(); commit();
        begin_cycle();
        bra_done = 1'b1; bra_mispredict = 1'b1; bra_id = 4'b0010;
        eval();
        chk("t4_squash_bc", 64'(cdb_bc), 64'h0);
        commit();
        begin_cycle(); eval();
        chk("t4_next_bc", 64'(cdb_bc), 64'h1);
        chk("t4_next_slot0", 64'(cdb_out[0].prd_s), 64'd41);
        commit();

        // Correct prediction clears the mask bit so a later mispredict spares it.
        reset_cycle();
        begin_cycle();
        push_unit(0, 6'd22, '0); push_unit(1, 6'd23, '0); push_unit(2, 6'd50, 4'b0011);
        eval(); commit();
        begin_cycle();
        bra_done = 1'b1; bra_mispredict = 1'b0; bra_id = 4'b0001;
        eval(); commit();
        begin_cycle();
        bra_done = 1'b1; bra_mispredict = 1'b1; bra_id = 4'b0001;
        eval();
        chk("t5_survive_bc", 64'(cdb_bc), 64'h1);
        chk("t5_survive_slot0", 64'(cdb_out[0].prd_s), 64'd50);
        commit();

        // Late flush with five buffered results and a concurrent push.
        reset_cycle();
        begin_cycle();
        push_unit(0, 6'd60, '0); push_unit(1, 6'd61, '0);
        push_unit(2, 6'd62, '0); push_unit(3, 6'd63, '0);
        eval(); commit();
        begin_cycle();
        push_unit(0, 6'd64, '0); push_unit(1, 6'd65, '0); push_unit(3, 6'd67, '0);
        eval(); commit();
        begin_cycle();
        late_flush = 1'b1;
        push_unit(2, 6'd70, '0);
        eval();
        chk("t6_flush_bc", 64'(cdb_bc), 64'h0);
        commit();
        begin_cycle(); eval();
        chk("t6_empty_ready", 64'(eu_ready), 64'hF);
        chk("t6_after_bc", 64'(cdb_bc), 64'h0);
        commit();
        begin_cycle(); eval();
        chk("t6_after_bc2", 64'(cdb_bc), 64'h0);
        commit();

        // Randomised traffic against the model.
        for (int n = 0; n < 1200; n++) begin
            begin_cycle();
            rst        = ($urandom_range(0, 199) != 0);
            late_flush = ($urandom_range(0, 59) == 0);
            bra_done   = ($urandom_range(0, 5) == 0);
            bra_mispredict = $urandom_range(0, 1) == 1;
            bra_id     = 4'b0001 << $urandom_range(0, EBR_MASK_SIZE - 1);
            for (int i = 0; i < NEU; i++) begin
                eu_valid[i]    = ($urandom_range(0, 9) < 6);
                r              = {$urandom(), $urandom()};
                eu_data[i]     = r[DW-1:0];
                eu_ebr_mask[i] = ebr_mask_t'($urandom_range(0, 15) & $urandom_range(0, 15));
            end
            eval();
            commit();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
